wb_port_arbiter: RTL and testbench



---
 rtl/wb_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port shared by pipeline writeback and buffered MDU results
// Optional starvation guard (FORCE slot + stall_pipe) enabled by defining WB_STARVE_GUARD_EN.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        wb_mem_to_reg,
  input  logic [31:0] wb_read_data,
  input  logic [31:0] wb_alu_out,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        stall_pipe,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]       fifo_rd_q   [DEPTH];
  logic [31:0]      fifo_data_q [DEPTH];
  logic [DEPTH-1:0] live_q;
  logic [DEPTH-1:0] dead_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;
  logic        stall_q;

  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pipe_grant;
  logic        mdu_grant;
  logic [31:0] pipe_data;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign mdu_ready  = !reset && !fifo_full;
  assign push       = mdu_valid && mdu_ready;
  assign pipe_data  = wb_mem_to_reg ? wb_read_data : wb_alu_out;

  // A forced slot overrides the pipeline; otherwise the MDU only gets idle slots.
  assign pipe_grant = !stall_q && wb_valid;
  assign mdu_grant  = !fifo_empty && (stall_q || !wb_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      live_q   <= '0;
      dead_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pipe_grant && (wb_rd != 5'd0) && live_q[i] && (fifo_rd_q[i] == wb_rd)) begin
          dead_q[i] <= 1'b1;
        end
      end
      if (mdu_grant) begin
        live_q[rd_ptr_q] <= 1'b0;
        dead_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q         <= rd_ptr_q + PW'(1);
      end
      if (push) begin
        fifo_rd_q[wr_ptr_q]   <= mdu_rd;
        fifo_data_q[wr_ptr_q] <= mdu_data;
        live_q[wr_ptr_q]      <= 1'b1;
        dead_q[wr_ptr_q]      <= 1'b0;
        wr_ptr_q              <= wr_ptr_q + PW'(1);
      end
      case ({push, mdu_grant})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= 1'b0;
      if (pipe_grant) begin
        rf_we_q    <= (wb_rd != 5'd0);
        rf_waddr_q <= wb_rd;
        rf_wdata_q <= pipe_data;
      end else if (mdu_grant) begin
        rf_we_q    <= !dead_q[rd_ptr_q] && (fifo_rd_q[rd_ptr_q] != 5'd0);
        rf_waddr_q <= fifo_rd_q[rd_ptr_q];
        rf_wdata_q <= fifo_data_q[rd_ptr_q];
      end
    end
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT) + 1;

  typedef enum logic {ST_RUN, ST_FORCE} state_e;

  state_e        state_q;
  logic [SW-1:0] starve_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      starve_cnt_q <= '0;
      stall_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!fifo_empty && !mdu_grant) begin
            if (starve_cnt_q == SW'(STARVE_LIMIT - 1)) begin
              state_q      <= ST_FORCE;
              stall_q      <= 1'b1;
              starve_cnt_q <= '0;
            end else begin
              starve_cnt_q <= starve_cnt_q + SW'(1);
            end
          end else begin
            starve_cnt_q <= '0;
          end
        end
        default: begin
          state_q      <= ST_RUN;
          stall_q      <= 1'b0;
          starve_cnt_q <= '0;
        end
      endcase
    end
  end
`else
  assign stall_q = 1'b0;
`endif

  assign stall_pipe = stall_q;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for wb_port_arbiter (expected writes tagged with arrival cycle)
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_mem_to_reg;
  logic [31:0] wb_read_data;
  logic [31:0] wb_alu_out;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        stall_pipe;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   c;

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_read_data(wb_read_data), .wb_alu_out(wb_alu_out),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready), .stall_pipe(stall_pipe),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_wr(input int wc, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc = wc; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every observed write must match the oldest expected one, including its cycle.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got x%0d=0x%0h expected no write (cycle %0d)", rf_waddr, rf_wdata, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_addr", {27'd0, rf_waddr}, {27'd0, e.addr});
        chk("wr_data", rf_wdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d writes outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_mem_to_reg = 1'b0;
    wb_read_data = '0; wb_alu_out = '0; mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
    step(); step();
    chk("rst_mdu_ready", {31'd0, mdu_ready}, 0);
    chk("rst_rf_we", {31'd0, rf_we}, 0);
    chk("rst_waddr", {27'd0, rf_waddr}, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_stall", {31'd0, stall_pipe}, 0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", {31'd0, mdu_ready}, 1);
    step();

    // Pipeline only, both MemToReg selections
    c = cyc;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_mem_to_reg = 1'b1;
    wb_read_data = 32'hDEADBEEF; wb_alu_out = 32'h1;
    expect_wr(c + 1, 5'd5, 32'hDEADBEEF);
    step();
    wb_mem_to_reg = 1'b0;
    expect_wr(c + 2, 5'd5, 32'h1);
    step();
    wb_valid = 1'b0;
    step(); step();
    chk("q_empty_pipe", exp_q.size(), 0);

    // rd=0 pipeline write is dropped
    wb_valid = 1'b1; wb_rd = 5'd0; wb_alu_out = 32'h77;
    step();
    wb_valid = 1'b0;
    chk("rd0_we", {31'd0, rf_we}, 0);
    step();

    // Idle-slot drain
    c = cyc;
    chk("drain_ready0", {31'd0, mdu_ready}, 1);
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h12345678;
    expect_wr(c + 2, 5'd7, 32'h12345678);
    step();
    mdu_valid = 1'b0;
    chk("drain_ready1", {31'd0, mdu_ready}, 1);
    step();
    chk("drain_ready2", {31'd0, mdu_ready}, 1);
    step(); step();
    chk("q_empty_drain", exp_q.size(), 0);

    // FIFO full under continuous pipeline traffic
    c = cyc;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_mem_to_reg = 1'b0; wb_alu_out = 32'hA0;
    mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_data = 32'h1010;
    expect_wr(c + 1, 5'd3, 32'hA0);
    step();
    chk("full_ready_c1", {31'd0, mdu_ready}, 1);
    mdu_rd = 5'd11; mdu_data = 32'h1111;
    expect_wr(c + 2, 5'd3, 32'hA0);
    step();
    chk("full_ready_c2", {31'd0, mdu_ready}, 0);
    mdu_rd = 5'd12; mdu_data = 32'h1212;
    expect_wr(c + 3, 5'd3, 32'hA0);
    step();
    chk("full_ready_c3", {31'd0, mdu_ready}, 0);
    mdu_valid = 1'b0; wb_valid = 1'b0;
    expect_wr(c + 4, 5'd10, 32'h1010);
    expect_wr(c + 5, 5'd11, 32'h1111);
    step();
    chk("full_ready_c4", {31'd0, mdu_ready}, 1);
    step();
    chk("full_ready_c5", {31'd0, mdu_ready}, 1);
    step(); step();
    chk("q_empty_full", exp_q.size(), 0);

    // Starvation: one MDU entry against back-to-back pipeline instructions 0x40+k
    c = cyc;
    wb_rd = 5'd4; wb_mem_to_reg = 1'b0;
    mdu_valid = 1'b1; mdu_rd = 5'd13; mdu_data = 32'hD13D;
    for (int k = 0; k < 7; k++) begin
      wb_valid = 1'b1;
`ifdef WB_STARVE_GUARD_EN
      wb_alu_out = 32'h40 + ((k == 6) ? 5 : k);
      chk("starve_stall", {31'd0, stall_pipe}, (k == 5) ? 1 : 0);
      if (k == 5) expect_wr(c + 6, 5'd13, 32'hD13D);
      else        expect_wr(c + k + 1, 5'd4, 32'h40 + ((k == 6) ? 5 : k));
`else
      wb_alu_out = 32'h40 + k;
      chk("starve_stall", {31'd0, stall_pipe}, 0);
      expect_wr(c + k + 1, 5'd4, 32'h40 + k);
`endif
      step();
      mdu_valid = 1'b0;
    end
    wb_valid = 1'b0;
`ifndef WB_STARVE_GUARD_EN
    expect_wr(c + 8, 5'd13, 32'hD13D);
`endif
    step(); step(); step();
    chk("q_empty_starve", exp_q.size(), 0);

    // WAW: same-cycle push survives, an older buffered entry is killed
    c = cyc;
    wb_valid = 1'b1; wb_rd = 5'd9; wb_alu_out = 32'h9A;
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h9999;
    expect_wr(c + 1, 5'd9, 32'h9A);
    step();
    wb_valid = 1'b0; mdu_valid = 1'b0;
    expect_wr(c + 2, 5'd9, 32'h9999);
    step();
    wb_valid = 1'b1; wb_rd = 5'd8; wb_alu_out = 32'h80;
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h5555;
    expect_wr(c + 3, 5'd8, 32'h80);
    step();
    mdu_valid = 1'b0; wb_rd = 5'd9; wb_alu_out = 32'h9B;
    expect_wr(c + 4, 5'd9, 32'h9B);
    step();
    wb_valid = 1'b0;
    step();
    chk("waw_dead_we", {31'd0, rf_we}, 0);
    chk("waw_ready", {31'd0, mdu_ready}, 1);
    step(); step();
    chk("q_empty_waw", exp_q.size(), 0);

    // Reset with two entries buffered
    c = cyc;
    wb_valid = 1'b1; wb_rd = 5'd6; wb_alu_out = 32'h66;
    mdu_valid = 1'b1; mdu_rd = 5'd14; mdu_data = 32'hE14;
    expect_wr(c + 1, 5'd6, 32'h66);
    step();
    mdu_rd = 5'd15; mdu_data = 32'hF15;
    expect_wr(c + 2, 5'd6, 32'h66);
    step();
    mdu_valid = 1'b0; wb_valid = 1'b0; reset = 1'b1;
    #1;
    chk("rst2_ready_low", {31'd0, mdu_ready}, 0);
    step();
    reset = 1'b0;
    #1;
    chk("rst2_ready_high", {31'd0, mdu_ready}, 1);
    chk("rst2_we", {31'd0, rf_we}, 0);
    step();
    chk("rst2_we_next", {31'd0, rf_we}, 0);
    step(); step(); step();
    chk("q_empty_final", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
